// File: rtl/ssid_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ssid_write_scheduler
// Purpose  : Round-robin SSID arbiter feeding registered writes to HNM, with
//            an event state machine (IDLE/RUN/DRAIN/DONE) and write counter.
// Revision : 1.0
// ============================================================================
module ssid_write_scheduler #(
  parameter int SSIDBITS  = 16,
  parameter int NREQ      = 4,
  parameter int COUNTBITS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*SSIDBITS-1:0] req_SSID,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     start,
  input  logic                     endEvent,
  input  logic                     HNM_writeReady,
  input  logic                     HCM_writeReady,
  input  logic                     HIM_writeReady,
  input  logic                     HNM_busy,
  input  logic                     HCM_busy,
  input  logic                     HIM_busy,
  output logic                     HNM_write,
  output logic [SSIDBITS-1:0]      HNM_SSID_toWrite,
  output logic [1:0]               grantIndex,
  output logic [COUNTBITS-1:0]     nWritten,
  output logic                     eventDone,
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] c_DRAIN_LAST = 3'd3;

  state_t                r_state;
  state_t                w_stateNext;
  logic [2:0]            r_drainCnt;
  logic [2:0]            w_drainCntNext;
  logic                  r_hnmWrite;
  logic [SSIDBITS-1:0]   r_ssid;
  logic [1:0]            r_grantIndex;
  logic [COUNTBITS-1:0]  r_nWritten;

  logic                  w_downOk;
  logic                  w_found;
  logic [1:0]            w_sel;
  logic [1:0]            w_cand;
  logic [NREQ-1:0]       w_ready;
  logic                  w_drainIdle;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_downOk = HNM_writeReady & HCM_writeReady & HIM_writeReady;
    w_found  = 1'b0;
    w_sel    = r_grantIndex;
    w_cand   = r_grantIndex;
    w_ready  = '0;
    if (r_state == S_RUN && w_downOk) begin
      for (int k = 1; k <= 4; k++) begin
        w_cand = r_grantIndex + 2'(k);
        if (!w_found && req_valid[w_cand]) begin
          w_found = 1'b1;
          w_sel   = w_cand;
        end
      end
    end
    if (w_found) begin
      w_ready = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_drainCntNext = '0;
    w_drainIdle    = !r_hnmWrite && !HNM_busy && !HCM_busy && !HIM_busy;
    case (r_state)
      S_IDLE:  if (start) w_stateNext = S_RUN;
      S_RUN:   if (endEvent) w_stateNext = S_DRAIN;
      S_DRAIN: begin
        if (w_drainIdle) begin
          w_drainCntNext = r_drainCnt + 3'd1;
          if (r_drainCnt == c_DRAIN_LAST) w_stateNext = S_DONE;
        end
      end
      S_DONE:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_drainCnt   <= '0;
      r_hnmWrite   <= 1'b0;
      r_ssid       <= '0;
      r_grantIndex <= 2'd3;
      r_nWritten   <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_drainCnt <= w_drainCntNext;
      r_hnmWrite <= w_found;
      if (w_found) begin
        r_ssid       <= req_SSID[w_sel*SSIDBITS +: SSIDBITS];
        r_grantIndex <= w_sel;
      end
      // Start clears the count; otherwise count strobes, saturating at all-ones.
      if (r_state == S_IDLE && start) begin
        r_nWritten <= '0;
      end else if (r_hnmWrite && (r_nWritten != '1)) begin
        r_nWritten <= r_nWritten + 1'b1;
      end
    end
  end

  assign req_ready        = w_ready;
  assign HNM_write        = r_hnmWrite;
  assign HNM_SSID_toWrite = r_ssid;
  assign grantIndex       = r_grantIndex;
  assign nWritten         = r_nWritten;
  assign eventDone        = (r_state == S_DONE);
  assign state            = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ssid_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssid_write_scheduler
// Purpose  : Directed self-checking bench for ssid_write_scheduler.
// Revision : 1.0
// ============================================================================
module tb_ssid_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_SSID;
  logic        start, endEvent;
  logic        HNM_writeReady, HCM_writeReady, HIM_writeReady;
  logic        HNM_busy, HCM_busy, HIM_busy;

  logic [3:0]  req_ready;
  logic        HNM_write;
  logic [15:0] HNM_SSID_toWrite;
  logic [1:0]  grantIndex;
  logic [15:0] nWritten;
  logic        eventDone;
  logic [1:0]  state;

  logic [3:0]  req_ready2;
  logic        HNM_write2;
  logic [15:0] HNM_SSID_toWrite2;
  logic [1:0]  grantIndex2;
  logic [1:0]  nWritten2;
  logic        eventDone2;
  logic [1:0]  state2;

  int checks = 0;
  int errors = 0;
  logic [15:0] expSsid [4];

  always #5 clk = ~clk;

  ssid_write_scheduler #(.SSIDBITS(16), .NREQ(4), .COUNTBITS(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_SSID(req_SSID),
    .req_ready(req_ready), .start(start), .endEvent(endEvent),
    .HNM_writeReady(HNM_writeReady), .HCM_writeReady(HCM_writeReady),
    .HIM_writeReady(HIM_writeReady), .HNM_busy(HNM_busy), .HCM_busy(HCM_busy),
    .HIM_busy(HIM_busy), .HNM_write(HNM_write), .HNM_SSID_toWrite(HNM_SSID_toWrite),
    .grantIndex(grantIndex), .nWritten(nWritten), .eventDone(eventDone), .state(state)
  );

  // Narrow-counter instance sharing all stimulus, used for saturation.
  ssid_write_scheduler #(.SSIDBITS(16), .NREQ(4), .COUNTBITS(2)) dutSat (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_SSID(req_SSID),
    .req_ready(req_ready2), .start(start), .endEvent(endEvent),
    .HNM_writeReady(HNM_writeReady), .HCM_writeReady(HCM_writeReady),
    .HIM_writeReady(HIM_writeReady), .HNM_busy(HNM_busy), .HCM_busy(HCM_busy),
    .HIM_busy(HIM_busy), .HNM_write(HNM_write2), .HNM_SSID_toWrite(HNM_SSID_toWrite2),
    .grantIndex(grantIndex2), .nWritten(nWritten2), .eventDone(eventDone2), .state(state2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    expSsid[0] = 16'h0408; expSsid[1] = 16'hA001;
    expSsid[2] = 16'hA002; expSsid[3] = 16'hA003;
    reset = 1'b0; req_valid = '0;
    req_SSID = {16'hA003, 16'hA002, 16'hA001, 16'h0408};
    start = 1'b0; endEvent = 1'b0;
    HNM_writeReady = 1'b1; HCM_writeReady = 1'b1; HIM_writeReady = 1'b1;
    HNM_busy = 1'b0; HCM_busy = 1'b0; HIM_busy = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_state", 32'(state), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_write", 32'(HNM_write), 0);
    check("rst_ssid", 32'(HNM_SSID_toWrite), 0);
    check("rst_grant", 32'(grantIndex), 3);
    check("rst_count", 32'(nWritten), 0);
    check("rst_done", 32'(eventDone), 0);
    reset = 1'b1;

    // Single transfer from requester 0
    start = 1'b1; tick(); start = 1'b0;
    check("run_state", 32'(state), 1);
    req_valid = 4'b0001; #1;
    check("single_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    check("single_write", 32'(HNM_write), 1);
    check("single_ssid", 32'(HNM_SSID_toWrite), 32'h0408);
    check("single_grant", 32'(grantIndex), 0);
    tick();
    check("single_nowrite", 32'(HNM_write), 0);
    check("single_count", 32'(nWritten), 1);
    check("single_count_sat", 32'(nWritten2), 1);

    // Reset in the cycle following a transfer
    req_valid = 4'b0100; #1;
    check("rr_skip_ready", 32'(req_ready), 32'h4);
    tick(); req_valid = '0;
    check("pre_rst_write", 32'(HNM_write), 1);
    #2 reset = 1'b0; #1;
    check("midrst_write", 32'(HNM_write), 0);
    check("midrst_state", 32'(state), 0);
    check("midrst_count", 32'(nWritten), 0);
    check("midrst_grant", 32'(grantIndex), 3);
    tick(); reset = 1'b1;
    tick();
    check("postrst_write", 32'(HNM_write), 0);
    check("postrst_state", 32'(state), 0);

    // Eight back-to-back round-robin grants
    start = 1'b1; tick(); start = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rr_ready", 32'(req_ready), 32'(1 << (i % 4)));
      tick();
      check("rr_write", 32'(HNM_write), 1);
      check("rr_ssid", 32'(HNM_SSID_toWrite), 32'(expSsid[i % 4]));
      check("rr_grant", 32'(grantIndex), 32'(i % 4));
    end
    req_valid = '0;
    tick();
    check("rr_count", 32'(nWritten), 8);
    check("rr_count_saturated", 32'(nWritten2), 3);
    check("rr_idle_write", 32'(HNM_write), 0);

    // Downstream stall holds the round-robin pointer
    req_valid = 4'b1111; HCM_writeReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", 32'(req_ready), 0);
      tick();
      check("stall_write", 32'(HNM_write), 0);
    end
    HCM_writeReady = 1'b1; #1;
    check("resume_ready0", 32'(req_ready), 32'h1);
    tick();
    check("resume_grant0", 32'(grantIndex), 0);
    check("resume_write0", 32'(HNM_write), 1);
    check("resume_ready1", 32'(req_ready), 32'h2);
    tick(); req_valid = '0;
    check("resume_grant1", 32'(grantIndex), 1);

    // endEvent with same-cycle transfer, then drain against HIM_busy
    req_valid = 4'b0100; endEvent = 1'b1; #1;
    check("end_ready", 32'(req_ready), 32'h4);
    tick();
    endEvent = 1'b0; req_valid = '0; HIM_busy = 1'b1;
    check("drain_state", 32'(state), 2);
    check("drain_write", 32'(HNM_write), 1);
    check("drain_ssid", 32'(HNM_SSID_toWrite), 32'hA002);
    check("drain_ready", 32'(req_ready), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("drain_busy_state", 32'(state), 2);
    end
    HIM_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("drain_idle_state", 32'(state), 2);
      check("drain_idle_done", 32'(eventDone), 0);
    end
    tick();
    check("done_state", 32'(state), 3);
    check("done_pulse", 32'(eventDone), 1);
    tick();
    check("after_done_state", 32'(state), 0);
    check("after_done_pulse", 32'(eventDone), 0);
    check("after_done_count", 32'(nWritten), 11);

    // endEvent ignored in IDLE; start+endEvent together go to RUN only
    endEvent = 1'b1; tick(); endEvent = 1'b0;
    check("idle_end_ignored", 32'(state), 0);
    check("idle_count_hold", 32'(nWritten), 11);
    start = 1'b1; endEvent = 1'b1; tick();
    start = 1'b0; endEvent = 1'b0;
    check("start_end_state", 32'(state), 1);
    check("start_clears_count", 32'(nWritten), 0);
    tick();
    check("start_end_stays_run", 32'(state), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
